// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and a per-register
// pending-write scoreboard that raises a decode stall on uncovered RAW hazards.
module regfile_scoreboard #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CW   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_result,
    input  logic [AW-1:0]   rs1_d,
    input  logic [AW-1:0]   rs2_d,
    input  logic            rs1_use,
    input  logic            rs2_use,
    input  logic            issue_valid,
    input  logic            issue_regwrite,
    input  logic [AW-1:0]   issue_rd,
    input  logic            cancel_valid,
    input  logic [AW-1:0]   cancel_rd,
    output logic [XLEN-1:0] rd1_d,
    output logic [XLEN-1:0] rd2_d,
    output logic            stall_d,
    output logic            sb_err
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [CW-1:0]   cnt_q  [NREG];
    logic [CW-1:0]   cnt_d  [NREG];
    logic [CW:0]     up     [NREG];
    logic [1:0]      dec    [NREG];
    logic            err_q, err_d;

    logic wb_hit1, wb_hit2, busy1, busy2, sat_stall, inc_en;

    assign wb_hit1 = wb_regwrite && (wb_rd == rs1_d) && (rs1_d != '0);
    assign wb_hit2 = wb_regwrite && (wb_rd == rs2_d) && (rs2_d != '0);

    assign rd1_d = (rs1_d == '0) ? '0 : (wb_hit1 ? wb_result : regs_q[rs1_d]);
    assign rd2_d = (rs2_d == '0) ? '0 : (wb_hit2 ? wb_result : regs_q[rs2_d]);

    // A retiring last writer is covered by the bypass, so it does not count as busy.
    assign busy1 = cnt_q[rs1_d] > CW'(wb_hit1);
    assign busy2 = cnt_q[rs2_d] > CW'(wb_hit2);

    assign sat_stall = issue_valid && issue_regwrite && (issue_rd != '0)
                    && (cnt_q[issue_rd] == {CW{1'b1}})
                    && !(wb_regwrite && (wb_rd == issue_rd))
                    && !(cancel_valid && (cancel_rd == issue_rd));

    assign stall_d = (rs1_use && (rs1_d != '0) && busy1)
                  || (rs2_use && (rs2_d != '0) && busy2)
                  || sat_stall;

    assign inc_en = issue_valid && issue_regwrite && !stall_d;
    assign sb_err = err_q;

    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            up[r]    = '0;
            dec[r]   = '0;
            if (r != 0) begin
                up[r]  = {1'b0, cnt_q[r]} + (CW+1)'(inc_en && (issue_rd == AW'(r)));
                dec[r] = {1'b0, wb_regwrite && (wb_rd == AW'(r))}
                       + {1'b0, cancel_valid && (cancel_rd == AW'(r))};
                if (up[r] < (CW+1)'(dec[r])) begin
                    cnt_d[r] = '0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d[r] = CW'(up[r] - (CW+1)'(dec[r]));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (wb_regwrite && (wb_rd != '0)) begin
                regs_q[wb_rd] <= wb_result;
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against a behavioural model.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            wb_regwrite;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_result;
    logic [AW-1:0]   rs1_d, rs2_d;
    logic            rs1_use, rs2_use;
    logic            issue_valid, issue_regwrite;
    logic [AW-1:0]   issue_rd;
    logic            cancel_valid;
    logic [AW-1:0]   cancel_rd;
    logic [XLEN-1:0] rd1_d, rd2_d;
    logic            stall_d, sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_reg [NREG];
    int              m_cnt [NREG];
    bit              m_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .CW(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rs1_use       (rs1_use),
        .rs2_use       (rs2_use),
        .issue_valid   (issue_valid),
        .issue_regwrite(issue_regwrite),
        .issue_rd      (issue_rd),
        .cancel_valid  (cancel_valid),
        .cancel_rd     (cancel_rd),
        .rd1_d         (rd1_d),
        .rd2_d         (rd2_d),
        .stall_d       (stall_d),
        .sb_err        (sb_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        int pending;
        pending = m_cnt[r] - ((wb_regwrite && int'(wb_rd) == r) ? 1 : 0);
        return pending > 0;
    endfunction

    function automatic bit m_stall();
        bit s;
        int r;
        s = 1'b0;
        if (rs1_use && rs1_d != 0 && m_busy(int'(rs1_d))) s = 1'b1;
        if (rs2_use && rs2_d != 0 && m_busy(int'(rs2_d))) s = 1'b1;
        r = int'(issue_rd);
        if (issue_valid && issue_regwrite && r != 0 && m_cnt[r] == CMAX
            && !(wb_regwrite && wb_rd == issue_rd)
            && !(cancel_valid && cancel_rd == issue_rd)) s = 1'b1;
        return s;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (wb_regwrite && wb_rd == rs) return wb_result;
        return m_reg[rs];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_edge(input bit stall);
        int n;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int r = 1; r < NREG; r++) begin
            n = m_cnt[r];
            if (issue_valid && issue_regwrite && !stall && int'(issue_rd) == r) n++;
            if (wb_regwrite && int'(wb_rd) == r) n--;
            if (cancel_valid && int'(cancel_rd) == r) n--;
            if (n < 0) begin
                n = 0;
                m_err = 1'b1;
            end
            m_cnt[r] = n;
        end
        if (wb_regwrite && wb_rd != 0) m_reg[wb_rd] = wb_result;
    endtask

    // Inputs change just after the falling edge; outputs checked 1 ns later.
    task automatic tick();
        bit s;
        #1;
        s = m_stall();
        check_eq("rd1", rd1_d, m_read(rs1_d));
        check_eq("rd2", rd2_d, m_read(rs2_d));
        check_eq("stall", stall_d, s);
        check_eq("sb_err", sb_err, m_err);
        @(posedge clk);
        model_edge(s);
        @(negedge clk);
    endtask

    task automatic idle();
        reset_n = 1'b1; wb_regwrite = 1'b0; wb_rd = '0; wb_result = '0;
        rs1_d = '0; rs2_d = '0; rs1_use = 1'b0; rs2_use = 1'b0;
        issue_valid = 1'b0; issue_regwrite = 1'b0; issue_rd = '0;
        cancel_valid = 1'b0; cancel_rd = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        idle();
        issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = rd;
    endtask

    task automatic wb(input logic [AW-1:0] rd, input logic [XLEN-1:0] val);
        idle();
        wb_regwrite = 1'b1; wb_rd = rd; wb_result = val;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        idle();
        rs1_d = 5'd6; rs1_use = 1'b1;
        #1;
        check_eq("reset_rd1", rd1_d, 0);
        check_eq("reset_stall", stall_d, 0);
        check_eq("reset_err", sb_err, 0);
        tick();

        // Basic write and x0 behaviour
        wb(5, 32'hDEADBEEF); tick();
        idle(); rs1_d = 5; rs2_d = 0; #1;
        check_eq("x5_read", rd1_d, 32'hDEADBEEF);
        check_eq("x0_read", rd2_d, 0);
        tick();
        wb(0, 32'h1234); tick();
        idle(); rs1_d = 0; rs1_use = 1'b1; #1;
        check_eq("x0_after_wr", rd1_d, 0);
        tick();

        // Bypass with a single pending writer (sb_err already set by the prior wb)
        issue(7); tick();
        issue(7); tick();
        wb(7, 32'h11); tick();
        wb(7, 32'h22); rs1_d = 7; rs2_d = 7; rs1_use = 1'b1; rs2_use = 1'b1; #1;
        check_eq("bypass_rd1", rd1_d, 32'h22);
        check_eq("bypass_rd2", rd2_d, 32'h22);
        check_eq("bypass_stall", stall_d, 0);
        tick();

        // RAW stall until writeback
        issue(3); tick();
        for (int i = 0; i < 2; i++) begin
            idle(); rs1_d = 3; rs1_use = 1'b1; #1;
            check_eq("raw_stall", stall_d, 1);
            tick();
        end
        wb(3, 32'hABCD); rs1_d = 3; rs1_use = 1'b1; #1;
        check_eq("raw_release", stall_d, 0);
        check_eq("raw_bypass", rd1_d, 32'hABCD);
        tick();

        // Saturation
        for (int i = 0; i < 3; i++) begin
            issue(9); tick();
        end
        issue(9); #1;
        check_eq("sat_stall", stall_d, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); rs1_d = 9; rs1_use = 1'b1; #1;
            check_eq("sat_busy", stall_d, 1);
            wb(9, i); tick();
        end
        idle(); rs1_d = 9; rs1_use = 1'b1; #1;
        check_eq("sat_drained", stall_d, 0);
        tick();

        // Cancel plus simultaneous events, after a clean reset
        idle(); reset_n = 1'b0; tick();
        issue(4); tick();
        issue(4); tick();
        issue(4); wb_regwrite = 1'b1; wb_rd = 4; wb_result = 32'h44;
        cancel_valid = 1'b1; cancel_rd = 4; tick();
        idle(); rs1_d = 4; rs1_use = 1'b1; #1;
        check_eq("net_cnt1_busy", stall_d, 1);
        check_eq("net_no_err", sb_err, 0);
        tick();
        idle(); cancel_valid = 1'b1; cancel_rd = 4; tick();
        idle(); cancel_valid = 1'b1; cancel_rd = 4; tick();
        for (int i = 0; i < 2; i++) begin
            idle(); #1;
            check_eq("err_sticky", sb_err, 1);
            tick();
        end

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            issue(6); tick();
        end
        wb(6, 32'h55); tick();
        idle(); reset_n = 1'b0; tick();
        idle(); rs1_d = 6; rs1_use = 1'b1; #1;
        check_eq("rst_rd6", rd1_d, 0);
        check_eq("rst_stall", stall_d, 0);
        check_eq("rst_err", sb_err, 0);
        tick();

        // Randomized traffic over a small register window
        for (int c = 0; c < 600; c++) begin
            idle();
            reset_n        = ($urandom_range(63) != 0);
            wb_regwrite    = ($urandom_range(9) < 3);
            wb_rd          = AW'($urandom_range(7));
            wb_result      = $urandom;
            rs1_d          = AW'($urandom_range(7));
            rs2_d          = AW'($urandom_range(7));
            rs1_use        = $urandom_range(1) == 1;
            rs2_use        = $urandom_range(1) == 1;
            issue_valid    = ($urandom_range(9) < 5);
            issue_regwrite = ($urandom_range(9) < 8);
            issue_rd       = AW'($urandom_range(7));
            cancel_valid   = ($urandom_range(9) == 0);
            cancel_rd      = AW'($urandom_range(7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Architectural integer register file that consumes the writeback port (wb_regwrite, wb_rd, wb_result) from the writeback stage. Serves two decode-stage read ports with same-cycle write-through bypass. Tracks in-flight destination registers in a per-register pending-write scoreboard and raises a decode stall on RAW hazards the bypass cannot cover. Sits between the decode and writeback stages of the 5-stage pipeline.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers; x0 hardwired to zero
AW, 5, register address width, clog2(NREG)
CW, 2, pending-write counter width per register; saturates at 2^CW-1

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
wb_regwrite  input  1  writeback enable from writeback stage
wb_rd  input  AW  writeback destination register
wb_result  input  XLEN  writeback data
rs1_d  input  AW  decode source register 1
rs2_d  input  AW  decode source register 2
rs1_use  input  1  decode instruction reads rs1
rs2_use  input  1  decode instruction reads rs2
issue_valid  input  1  decode instruction leaves decode this cycle
issue_regwrite  input  1  issuing instruction writes a register
issue_rd  input  AW  issuing instruction destination
cancel_valid  input  1  a previously issued writer was squashed and will never write back
cancel_rd  input  AW  destination of the squashed writer
rd1_d  output  XLEN  read data for rs1_d
rd2_d  output  XLEN  read data for rs2_d
stall_d  output  1  hold decode; issue is ignored while high
sb_err  output  1  sticky scoreboard underflow flag

Behaviour:
- Reset (reset_n low at a rising edge): all registers 0, all counters 0, sb_err 0. Writes, issues and cancels in that cycle are dropped. After reset, rd1_d and rd2_d read 0 and stall_d is 0.
- x0: never written. Counter for x0 is never incremented or decremented. Reads of x0 return 0 and never stall.
- Write: at the rising edge, if wb_regwrite and wb_rd != 0, then reg[wb_rd] <= wb_result.
- Read: rd1_d and rd2_d are combinational, zero latency. If wb_regwrite and wb_rd == rs (rs != 0), the port returns wb_result (write-through bypass). Otherwise it returns reg[rs]. Both ports may address the same register.
- Counter update per register r, once per cycle, net: cnt[r] + inc - dec_wb - dec_cancel.
  - inc = issue_valid & issue_regwrite & !stall_d & issue_rd == r.
  - dec_wb = wb_regwrite & wb_rd == r.
  - dec_cancel = cancel_valid & cancel_rd == r.
  - Simultaneous inc and dec on the same r: the net applies. +1-1 leaves the counter unchanged; +1-2 decrements by 1.
- Underflow: if the net would go below 0, cnt[r] <= 0 and sb_err <= 1. sb_err stays set until reset.
- busy_eff(r) = (cnt[r] - dec_wb(r)) > 0, using the current-cycle wb. A retiring last writer is covered by the bypass and does not stall.
- stall_d = (rs1_use & rs1_d != 0 & busy_eff(rs1_d)) | (rs2_use & rs2_d != 0 & busy_eff(rs2_d)) | (issue_valid & issue_regwrite & issue_rd != 0 & cnt[issue_rd] == 2^CW-1 & !dec_wb(issue_rd) & !dec_cancel(issue_rd)).
  - The last term is saturation: an issue that would overflow the counter stalls instead.
- While stall_d is high, issue_valid has no effect on the counters. stall_d depends only on current inputs and state, with no registered latency.
- Reset takes priority over everything. Reset asserted mid-flight clears every counter; in-flight writebacks arriving after reset decrement a zero counter and set sb_err. The pipeline must flush alongside.

Test Plan:
1. Reset, then write x5=0xDEADBEEF via wb_regwrite=1, wb_rd=5 -> next cycle rs1_d=5 reads 0xDEADBEEF. rs2_d=0 reads 0. A write to x0 of 0x1234 leaves x0 reading 0.
2. Same-cycle bypass: reg[7]=0x11, wb writes x7=0x22, rs1_d=rs2_d=7 -> rd1_d=rd2_d=0x22 in that cycle, with stall_d=0 when cnt[7]=1.
3. RAW stall: issue writer to x3, then decode rs1_d=3 with rs1_use=1 -> stall_d=1 each cycle until the wb to x3 cycle, where stall_d=0 and rd1_d=wb_result.
4. Saturation: issue to x9 three times with no wb -> cnt=3. A fourth issue to x9 gives stall_d=1 and cnt stays 3. Then three wb to x9 -> cnt=0.
5. Cancel plus simultaneous events: cnt[4]=2, with wb to x4, cancel x4 and an issue to x4 in one cycle -> cnt[4]=1, sb_err=0. A cancel at cnt=0 -> sb_err=1, held until reset.
6. Reset mid-flight: cnt[6]=2 and reg[6]=0x55, assert reset_n=0 for one edge -> all counters 0, rd of x6 = 0, stall_d=0, sb_err=0.
